lut_loader: RTL

//  Writer side of the branch-target lookup table. Holds DEPTH branch targets (TGT_W-bit

---
 rtl/lut_loader_pkg.sv | 15 +
 rtl/lut_loader.sv | 71 +++++++
 2 files changed

// File: rtl/lut_loader_pkg.sv
// Shared types for the branch-target table loader.
// Widths, loader state encoding and the target word type.
package lut_loader_pkg;
  localparam int ADDR_W = 4;
  localparam int TGT_W  = 10;
  localparam int DEPTH  = 9;

  typedef logic [TGT_W-1:0] target_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;
endpackage

// File: rtl/lut_loader.sv
// Branch-target table with an in-order valid/ready word loader.
// Combinational Addr->Target read port; Busy stalls fetch while loading.
module lut_loader
  import lut_loader_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int TW = TGT_W,
  parameter int DP = DEPTH
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          WrValid,
  input  logic [TW-1:0] WrData,
  output logic          WrReady,
  input  logic [AW-1:0] Addr,
  output logic [TW-1:0] Target,
  output logic          Busy,
  output logic          Done
);
  localparam int CW = (DP > 1) ? $clog2(DP) : 1;

  loader_state_t state, state_nx;
  logic [CW-1:0] count;
  logic [TW-1:0] tbl [DP];
  logic          xfer;
  logic          last;

  assign xfer = (state == LOAD) && WrValid;
  assign last = (count == CW'(DP - 1));

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      count <= '0;
      for (int i = 0; i < DP; i++) tbl[i] <= '0;
    end else begin
      state <= state_nx;
      if (xfer) begin
        tbl[count] <= WrData;
        count      <= last ? '0 : count + 1'b1;
      end else if (Start && state != LOAD) begin
        count <= '0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    WrReady  = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    Target   = '0;
    unique case (1'b1)
      state == IDLE: if (Start) state_nx = LOAD;
      state == LOAD: begin
        WrReady = 1'b1;
        Busy    = 1'b1;
        if (xfer && last) state_nx = DONE;
      end
      state == DONE: begin
        Done = 1'b1;
        if (Start) state_nx = LOAD;
      end
      default: state_nx = IDLE;
    endcase
    // Indices past DP read as zero
    for (int i = 0; i < DP; i++)
      if (Addr == AW'(i)) Target = tbl[i];
  end
endmodule
